// File: rtl/vga_sync_decoder_if.sv
// Sync inputs and recovered timing results of the VGA sync decoder.
interface vga_sync_decoder_if;
    logic        h_sync_in;
    logic        v_sync_in;
    logic [10:0] x_loc;
    logic [10:0] y_loc;
    logic        de;
    logic        locked;
    logic        lock_lost;
    logic [11:0] line_period;
    logic [11:0] hsync_width;
    logic [11:0] frame_lines;
    logic [7:0]  err_count;

    // Timing source side: drives the syncs, observes the decoder results.
    modport master (
        output h_sync_in, v_sync_in,
        input  x_loc, y_loc, de, locked, lock_lost,
               line_period, hsync_width, frame_lines, err_count
    );

    // Decoder side.
    modport slave (
        input  h_sync_in, v_sync_in,
        output x_loc, y_loc, de, locked, lock_lost,
               line_period, hsync_width, frame_lines, err_count
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers pixel position and data-enable from incoming
// h/v syncs, measures line period, hsync width and lines per frame, and
// runs a lock FSM that confirms the measured timing matches the mode.
module vga_sync_decoder #(
    parameter int H_RES         = 1280,
    parameter int H_FRONT_PORCH = 48,
    parameter int H_SYNC_PULSE  = 112,
    parameter int H_BACK_PORCH  = 248,
    parameter int V_RES         = 1024,
    parameter int V_FRONT_PORCH = 1,
    parameter int V_SYNC_PULSE  = 3,
    parameter int V_BACK_PORCH  = 38,
    parameter int SYNC_POL      = 1,
    parameter int LOCK_FRAMES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    vga_sync_decoder_if.slave bus
);
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    localparam int H_TOTAL      = H_RES + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL      = V_RES + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int H_SYNC_START = H_RES + H_FRONT_PORCH;
    localparam int V_SYNC_START = V_RES + V_FRONT_PORCH;

    // Active-low syncs are inverted on entry so everything downstream sees active-high.
    localparam logic        POL_INV     = (SYNC_POL == 0);
    localparam logic [11:0] SAT         = 12'hFFF;
    localparam logic [11:0] H_TOTAL_12  = 12'(H_TOTAL);
    localparam logic [11:0] V_TOTAL_12  = 12'(V_TOTAL);
    localparam logic [10:0] X_LAST      = 11'(H_TOTAL - 1);
    localparam logic [10:0] Y_LAST      = 11'(V_TOTAL - 1);
    localparam logic [10:0] X_SYNC      = 11'(H_SYNC_START);
    localparam logic [10:0] Y_SYNC      = 11'(V_SYNC_START);
    localparam logic [10:0] X_ACTIVE    = 11'(H_RES);
    localparam logic [10:0] Y_ACTIVE    = 11'(V_RES);
    localparam logic [3:0]  GOOD_TARGET = 4'(LOCK_FRAMES);

    logic        h_s1, h_s2, v_s1, v_s2;
    logic        h_lead, h_trail, v_lead;
    logic [11:0] h_per_cnt, h_wid_cnt, line_cnt, per_cap;
    logic        line_bad, period_bad, timeout, frame_ok;
    lock_state_t state_q, state_d;
    logic [3:0]  good_q, good_d;
    logic        lost_d;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic        de_q, locked_q, lock_lost_q;
    logic [11:0] line_period_q, hsync_width_q, frame_lines_q;
    logic [7:0]  err_q;

    assign h_lead  = h_s1 & ~h_s2;
    assign h_trail = ~h_s1 & h_s2;
    assign v_lead  = v_s1 & ~v_s2;

    // Period of the line ending at this h edge; the counter was zeroed on the previous edge.
    assign per_cap    = (h_per_cnt == SAT) ? SAT : h_per_cnt + 12'd1;
    assign period_bad = h_lead && (per_cap != H_TOTAL_12);
    // Counter pinned at its ceiling means hsync has gone missing.
    assign timeout    = !h_lead && (h_per_cnt == SAT);
    // An h edge coinciding with the v edge still has its own period judged here.
    assign frame_ok   = !line_bad && !period_bad && (line_cnt == V_TOTAL_12);

    // Two-flop sample of each sync, normalised to active-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_s1 <= 1'b0;
            h_s2 <= 1'b0;
            v_s1 <= 1'b0;
            v_s2 <= 1'b0;
        end else begin
            h_s1 <= bus.h_sync_in ^ POL_INV;
            h_s2 <= h_s1;
            v_s1 <= bus.v_sync_in ^ POL_INV;
            v_s2 <= v_s1;
        end
    end

    // Line period, hsync width and lines-per-frame measurement.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_per_cnt     <= '0;
            h_wid_cnt     <= '0;
            line_cnt      <= '0;
            line_bad      <= 1'b0;
            line_period_q <= '0;
            hsync_width_q <= '0;
            frame_lines_q <= '0;
        end else begin
            if (h_lead)                h_per_cnt <= '0;
            else if (h_per_cnt != SAT) h_per_cnt <= h_per_cnt + 12'd1;

            if (h_lead)       line_period_q <= per_cap;
            else if (timeout) line_period_q <= SAT;

            if (h_s1) h_wid_cnt <= (h_wid_cnt == SAT) ? SAT : h_wid_cnt + 12'd1;
            else      h_wid_cnt <= '0;
            if (h_trail) hsync_width_q <= h_wid_cnt;

            if (v_lead)                         line_cnt <= '0;
            else if (h_lead && line_cnt != SAT) line_cnt <= line_cnt + 12'd1;
            if (v_lead) frame_lines_q <= line_cnt;

            if (v_lead)          line_bad <= 1'b0;
            else if (period_bad) line_bad <= 1'b1;
        end
    end

    // Recovered position: sync edges re-seed the counters, otherwise free-run.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (h_lead)              x_d = X_SYNC;
        else if (x_q == X_LAST)  x_d = '0;
        else                     x_d = x_q + 11'd1;
        if (v_lead)                          y_d = Y_SYNC;
        else if (!h_lead && x_q == X_LAST)   y_d = (y_q == Y_LAST) ? '0 : y_q + 11'd1;
    end

    // Lock FSM next state; timeout overrides everything.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        lost_d  = 1'b0;
        if (timeout) begin
            state_d = SEARCH;
            good_d  = '0;
        end else begin
            case (state_q)
                SEARCH: if (v_lead) begin
                    // The frame in progress at acquisition is partial, never judged.
                    state_d = CHECK;
                    good_d  = '0;
                end
                CHECK: if (v_lead) begin
                    if (frame_ok) begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == GOOD_TARGET) state_d = LOCKED;
                    end else begin
                        good_d = '0;
                    end
                end
                LOCKED: if (period_bad || (v_lead && !frame_ok)) begin
                    state_d = CHECK;
                    good_d  = '0;
                end
                default: begin
                    state_d = SEARCH;
                    good_d  = '0;
                end
            endcase
        end
        lost_d = (state_q == LOCKED) && (state_d != LOCKED);
    end

    // Lock FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEARCH;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    // Registered position/status outputs, computed from next-state so de drops with locked.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            de_q        <= 1'b0;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
            err_q       <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            locked_q    <= (state_d == LOCKED);
            de_q        <= (state_d == LOCKED) && (x_d < X_ACTIVE) && (y_d < Y_ACTIVE);
            lock_lost_q <= lost_d;
            if (lost_d && err_q != 8'hFF) err_q <= err_q + 8'd1;
        end
    end

    assign bus.x_loc       = x_q;
    assign bus.y_loc       = y_q;
    assign bus.de          = de_q;
    assign bus.locked      = locked_q;
    assign bus.lock_lost   = lock_lost_q;
    assign bus.line_period = line_period_q;
    assign bus.hsync_width = hsync_width_q;
    assign bus.frame_lines = frame_lines_q;
    assign bus.err_count   = err_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a small VGA mode drives an active-high and an
// active-low decoder with the same timing; results are predicted from the
// generator's own position and the mode arithmetic.
module tb_vga_sync_decoder;
    localparam int H_RES = 16, HFP = 2, HSP = 4, HBP = 6;
    localparam int V_RES = 8,  VFP = 1, VSP = 2, VBP = 3;
    localparam int LF    = 2;
    localparam int HT    = H_RES + HFP + HSP + HBP;
    localparam int VT    = V_RES + VFP + VSP + VBP;
    localparam int HSS   = H_RES + HFP;
    localparam int VSS   = V_RES + VFP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_sync_decoder_if if_p ();
    vga_sync_decoder_if if_n ();

    vga_sync_decoder #(.H_RES(H_RES), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .H_BACK_PORCH(HBP),
                       .V_RES(V_RES), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP), .V_BACK_PORCH(VBP),
                       .SYNC_POL(1), .LOCK_FRAMES(LF))
        dut_p (.clk(clk), .rst(rst), .bus(if_p));

    vga_sync_decoder #(.H_RES(H_RES), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .H_BACK_PORCH(HBP),
                       .V_RES(V_RES), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP), .V_BACK_PORCH(VBP),
                       .SYNC_POL(0), .LOCK_FRAMES(LF))
        dut_n (.clk(clk), .rst(rst), .bus(if_n));

    int errors = 0;
    int checks = 0;

    // Generator model state.
    int gx = 0, gy = 0, line_len = HT;
    bit h_off = 1'b0;
    bit gh = 1'b0, gv = 1'b0, gv_prev = 1'b0;
    int vedges = 0;
    int xh1 = 0, xh2 = 0, yh1 = 0, yh2 = 0;
    bit scan_on = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_both(input string tag, input logic [31:0] gp, input logic [31:0] gn,
                            input logic [31:0] exp);
        chk({tag, "_pos"}, gp, exp);
        chk({tag, "_neg"}, gn, exp);
    endtask

    task automatic drive(input bit h, input bit v);
        if_p.h_sync_in = h;
        if_p.v_sync_in = v;
        if_n.h_sync_in = ~h;
        if_n.v_sync_in = ~v;
    endtask

    task automatic gen_step();
        gx++;
        if (gx >= line_len) begin
            gx       = 0;
            line_len = HT;
            gy       = (gy == VT - 1) ? 0 : gy + 1;
        end
        gh = !h_off && gx >= HSS && gx < HSS + HSP;
        gv = gy >= VSS && gy < VSS + VSP;
        if (gv && !gv_prev) vedges++;
        gv_prev = gv;
        drive(gh, gv);
    endtask

    // Decoder position should equal the generator position from two clocks earlier.
    task automatic scan_check();
        chk_both("x_loc", if_p.x_loc, if_n.x_loc, xh2);
        chk_both("y_loc", if_p.y_loc, if_n.y_loc, yh2);
        chk_both("de", if_p.de, if_n.de, (xh2 < H_RES && yh2 < V_RES) ? 1 : 0);
        chk_both("locked_scan", if_p.locked, if_n.locked, 1);
        chk_both("lock_lost_scan", if_p.lock_lost, if_n.lock_lost, 0);
    endtask

    // One clock: sample at the falling edge, then advance and drive the generator.
    task automatic step();
        @(negedge clk);
        if (scan_on) scan_check();
        gen_step();
        xh2 = xh1; xh1 = gx;
        yh2 = yh1; yh1 = gy;
    endtask

    task automatic run_vedges(input string tag, input int n);
        int start;
        int budget;
        start  = vedges;
        budget = (n + 2) * HT * VT;
        while (vedges - start < n && budget > 0) begin
            step();
            budget--;
        end
        chk({tag, "_vedge_wait"}, vedges - start, n);
    endtask

    // Lock must not be reached by the 2nd v edge and must appear 2 samples after the 3rd.
    task automatic expect_relock(input string tag);
        run_vedges(tag, 2);
        step(); step();
        chk_both({tag, "_not_early"}, if_p.locked, if_n.locked, 0);
        run_vedges(tag, 1);
        step();
        chk_both({tag, "_locked_m1"}, if_p.locked, if_n.locked, 0);
        step();
        chk_both({tag, "_locked"}, if_p.locked, if_n.locked, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_both({tag, "_x"}, if_p.x_loc, if_n.x_loc, 0);
        chk_both({tag, "_y"}, if_p.y_loc, if_n.y_loc, 0);
        chk_both({tag, "_de"}, if_p.de, if_n.de, 0);
        chk_both({tag, "_locked"}, if_p.locked, if_n.locked, 0);
        chk_both({tag, "_lost"}, if_p.lock_lost, if_n.lock_lost, 0);
        chk_both({tag, "_period"}, if_p.line_period, if_n.line_period, 0);
        chk_both({tag, "_width"}, if_p.hsync_width, if_n.hsync_width, 0);
        chk_both({tag, "_lines"}, if_p.frame_lines, if_n.frame_lines, 0);
        chk_both({tag, "_err"}, if_p.err_count, if_n.err_count, 0);
    endtask

    initial begin
        int len;
        int pulses_p, pulses_n;
        int guard;

        // Reset held with toggling syncs.
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(i[0], ~i[0]);
        end
        @(negedge clk);
        chk_all_zero("reset");

        // Acquire default timing from a random, sync-inactive start point.
        gx = $urandom_range(0, HSS - 3);
        gy = $urandom_range(0, VSS - 1);
        step();
        rst = 1'b0;
        expect_relock("acquire");
        chk_both("line_period", if_p.line_period, if_n.line_period, HT);
        chk_both("hsync_width", if_p.hsync_width, if_n.hsync_width, HSP);
        chk_both("frame_lines", if_p.frame_lines, if_n.frame_lines, VT);
        chk_both("err_initial", if_p.err_count, if_n.err_count, 0);
        scan_on = 1'b1;
        repeat (HT * VT) step();
        scan_on = 1'b0;

        // One short line while locked.
        len   = HT - 1 - int'($urandom_range(0, 3));
        guard = 0;
        while (gx != HSS + HSP && guard < 2 * HT) begin step(); guard++; end
        line_len = len;
        guard = 0;
        do begin step(); guard++; end while (!gh && guard < 2 * HT);
        chk("short_line_edge_seen", gh, 1);
        step();
        chk_both("short_locked_m1", if_p.locked, if_n.locked, 1);
        step();
        chk_both("short_locked", if_p.locked, if_n.locked, 0);
        chk_both("short_lost", if_p.lock_lost, if_n.lock_lost, 1);
        chk_both("short_err", if_p.err_count, if_n.err_count, 1);
        chk_both("short_period", if_p.line_period, if_n.line_period, len);
        step();
        chk_both("short_lost_end", if_p.lock_lost, if_n.lock_lost, 0);
        expect_relock("short_relock");

        // Hsync vanishes for 5000 clocks while locked.
        h_off    = 1'b1;
        pulses_p = 0;
        pulses_n = 0;
        repeat (5000) begin
            step();
            pulses_p += int'(if_p.lock_lost);
            pulses_n += int'(if_n.lock_lost);
        end
        chk_both("timeout_locked", if_p.locked, if_n.locked, 0);
        chk_both("timeout_period", if_p.line_period, if_n.line_period, 4095);
        chk_both("timeout_err", if_p.err_count, if_n.err_count, 2);
        chk_both("timeout_pulses", pulses_p, pulses_n, 1);
        guard = 0;
        while (!(gx == 0 && gy == 0) && guard < 2 * HT * VT) begin step(); guard++; end
        h_off = 1'b0;
        expect_relock("timeout_relock");

        // Reset pulse mid-frame while locked.
        repeat ($urandom_range(0, HT * VT - 1)) step();
        rst = 1'b1;
        step();
        chk_all_zero("midreset");
        guard = 0;
        do begin step(); guard++; end while ((gh || gv) && guard < 2 * HT * VT);
        rst = 1'b0;
        expect_relock("midreset_relock");
        chk_both("midreset_err", if_p.err_count, if_n.err_count, 0);
        chk_both("midreset_period", if_p.line_period, if_n.line_period, HT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
